// File: rtl/imu_tlm_pkg.sv
// Shared definitions for the IMU UART telemetry block: FSM encodings, frame
// header bytes, frame lengths and the snapshot layout.
package imu_tlm_pkg;

    localparam logic [2:0] ST_IDLE = 3'd0;
    localparam logic [2:0] ST_LOAD = 3'd1;
    localparam logic [2:0] ST_SEND = 3'd2;
    localparam logic [2:0] ST_NEXT = 3'd3;
    localparam logic [2:0] ST_DONE = 3'd4;

    localparam logic [7:0] HDR0 = 8'h55;
    localparam logic [7:0] HDR1 = 8'hAA;

    localparam int FRAME_LEN_BASE = 14;
    localparam int FRAME_LEN_CSUM = 15;
    localparam int IDX_W          = 4;

    typedef struct packed {
        logic [15:0] acc_x;
        logic [15:0] acc_y;
        logic [15:0] acc_z;
        logic [15:0] gyro_x;
        logic [15:0] gyro_y;
        logic [15:0] gyro_z;
    } imu_snap_t;

    // Header and data bytes of the base frame; high byte of each axis goes first.
    function automatic logic [7:0] frame_byte(input imu_snap_t s, input logic [IDX_W-1:0] idx);
        logic [7:0] b;
        case (idx)
            4'd0:    b = HDR0;
            4'd1:    b = HDR1;
            4'd2:    b = s.acc_x[15:8];
            4'd3:    b = s.acc_x[7:0];
            4'd4:    b = s.acc_y[15:8];
            4'd5:    b = s.acc_y[7:0];
            4'd6:    b = s.acc_z[15:8];
            4'd7:    b = s.acc_z[7:0];
            4'd8:    b = s.gyro_x[15:8];
            4'd9:    b = s.gyro_x[7:0];
            4'd10:   b = s.gyro_y[15:8];
            4'd11:   b = s.gyro_y[7:0];
            4'd12:   b = s.gyro_z[15:8];
            4'd13:   b = s.gyro_z[7:0];
            default: b = 8'hFF;
        endcase
        return b;
    endfunction

endpackage

// File: rtl/uart_tx_byte.sv
// 8N1 byte transmitter: start pulse loads a 10-bit frame, each bit held BAUD_DIV
// cycles; done is high during the final cycle of the stop bit.
module uart_tx_byte #(
    parameter int BAUD_DIV = 434
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic [7:0] data,
    output logic       tx,
    output logic       done
);
    localparam int TMR_W = $clog2(BAUD_DIV);

    logic [9:0]       shift_q, shift_d;
    logic [3:0]       bit_q, bit_d;
    logic [TMR_W-1:0] tmr_q, tmr_d;
    logic             active_q, active_d;

    always_comb begin
        shift_d  = shift_q;
        bit_d    = bit_q;
        tmr_d    = tmr_q;
        active_d = active_q;
        done     = active_q && (tmr_q == '0) && (bit_q == '0);
        if (start) begin
            shift_d  = {1'b1, data, 1'b0};
            bit_d    = 4'd9;
            tmr_d    = TMR_W'(BAUD_DIV - 1);
            active_d = 1'b1;
        end else if (active_q) begin
            if (tmr_q == '0) begin
                if (bit_q == '0) begin
                    active_d = 1'b0;
                end else begin
                    // Fill with ones so the line idles high once the stop bit is out.
                    shift_d = {1'b1, shift_q[9:1]};
                    bit_d   = bit_q - 4'd1;
                    tmr_d   = TMR_W'(BAUD_DIV - 1);
                end
            end else begin
                tmr_d = tmr_q - 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shift_q  <= '1;
            bit_q    <= '0;
            tmr_q    <= '0;
            active_q <= 1'b0;
        end else begin
            shift_q  <= shift_d;
            bit_q    <= bit_d;
            tmr_q    <= tmr_d;
            active_q <= active_d;
        end
    end

    assign tx = shift_q[0];

endmodule

// File: rtl/imu_uart_telemetry.sv
// Periodic snapshot of the six IMU axis words, sent as a framed 8N1 UART stream.
// IMU_TLM_CHECKSUM_EN appends a modulo-256 sum of the 12 data bytes.
//   state | meaning
//   IDLE  | waiting for a frame tick; snapshot captured on the tick
//   LOAD  | hand frame byte[idx] to the transmitter
//   SEND  | byte on the wire
//   NEXT  | advance idx or finish
//   DONE  | frame_done pulse, back to IDLE
module imu_uart_telemetry
    import imu_tlm_pkg::*;
#(
    parameter int CLK_HZ       = 50000000,
    parameter int BAUD         = 115200,
    parameter int FRAME_PERIOD = 500000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        enable,
    input  logic [15:0] acc_x,
    input  logic [15:0] acc_y,
    input  logic [15:0] acc_z,
    input  logic [15:0] gyro_x,
    input  logic [15:0] gyro_y,
    input  logic [15:0] gyro_z,
    output logic        tx,
    output logic        busy,
    output logic        frame_done,
    output logic        overrun
);
    localparam int BAUD_DIV_RAW = CLK_HZ / BAUD;
    localparam int BAUD_DIV     = (BAUD_DIV_RAW < 2) ? 2 : BAUD_DIV_RAW;
    localparam int CNT_W        = (FRAME_PERIOD > 2) ? $clog2(FRAME_PERIOD) : 1;
`ifdef IMU_TLM_CHECKSUM_EN
    localparam int FRAME_LEN    = FRAME_LEN_CSUM;
`else
    localparam int FRAME_LEN    = FRAME_LEN_BASE;
`endif
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(FRAME_LEN - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       state_q, state_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    imu_snap_t        snap_q, snap_d;
    logic             busy_q, busy_d;
    logic             frame_done_q, frame_done_d;
    logic             overrun_q, overrun_d;
    logic             tick;
    logic             tx_start;
    logic             tx_done;
    logic [7:0]       byte_sel;

    assign tick = enable && (cnt_q == CNT_W'(FRAME_PERIOD - 1));

    always_comb begin
        cnt_d = '0;
        if (enable && !tick) cnt_d = cnt_q + 1'b1;
    end

`ifdef IMU_TLM_CHECKSUM_EN
    logic [7:0] sum_q, sum_d;

    always_comb begin
        byte_sel = (idx_q == LAST_IDX) ? sum_q : frame_byte(snap_q, idx_q);
        sum_d    = sum_q;
        if (state_q == ST_IDLE && tick) begin
            sum_d = '0;
        end else if (state_q == ST_LOAD && idx_q >= IDX_W'(2) && idx_q <= IDX_W'(FRAME_LEN_BASE - 1)) begin
            sum_d = sum_q + byte_sel;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) sum_q <= '0;
        else        sum_q <= sum_d;
    end
`else
    assign byte_sel = frame_byte(snap_q, idx_q);
`endif

    always_comb begin
        state_d      = state_q;
        idx_d        = idx_q;
        snap_d       = snap_q;
        busy_d       = busy_q;
        frame_done_d = 1'b0;
        overrun_d    = overrun_q;
        tx_start     = 1'b0;
        // Ticks outside IDLE are dropped; only those seen while busy are flagged.
        if (tick && busy_q) overrun_d = 1'b1;
        case (state_q)
            ST_IDLE: begin
                if (tick) begin
                    snap_d  = '{acc_x, acc_y, acc_z, gyro_x, gyro_y, gyro_z};
                    busy_d  = 1'b1;
                    idx_d   = '0;
                    state_d = ST_LOAD;
                end
            end
            ST_LOAD: begin
                tx_start = 1'b1;
                state_d  = ST_SEND;
            end
            ST_SEND: begin
                if (tx_done) state_d = ST_NEXT;
            end
            ST_NEXT: begin
                if (idx_q == LAST_IDX) begin
                    busy_d       = 1'b0;
                    frame_done_d = 1'b1;
                    state_d      = ST_DONE;
                end else begin
                    idx_d   = idx_q + 1'b1;
                    state_d = ST_LOAD;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q        <= '0;
            state_q      <= ST_IDLE;
            idx_q        <= '0;
            snap_q       <= '0;
            busy_q       <= 1'b0;
            frame_done_q <= 1'b0;
            overrun_q    <= 1'b0;
        end else begin
            cnt_q        <= cnt_d;
            state_q      <= state_d;
            idx_q        <= idx_d;
            snap_q       <= snap_d;
            busy_q       <= busy_d;
            frame_done_q <= frame_done_d;
            overrun_q    <= overrun_d;
        end
    end

    uart_tx_byte #(
        .BAUD_DIV(BAUD_DIV)
    ) u_uart (
        .clk   (clk),
        .rst_n (rst_n),
        .start (tx_start),
        .data  (byte_sel),
        .tx    (tx),
        .done  (tx_done)
    );

    assign busy       = busy_q;
    assign frame_done = frame_done_q;
    assign overrun    = overrun_q;

endmodule

// File: tb/tb_imu_uart_telemetry.sv
// Directed bench: DUT A (FRAME_PERIOD=2000) for framing/coherence/enable,
// DUT B (FRAME_PERIOD=1000) for overrun and mid-frame reset.
module tb_imu_uart_telemetry;
    localparam int BDIV = 10;
`ifdef IMU_TLM_CHECKSUM_EN
    localparam int LEN = 15;
`else
    localparam int LEN = 14;
`endif
    localparam int FRAME_CYC = LEN * 10 * BDIV + 2 * (LEN - 1) + 2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n_a, rst_n_b, en_a, en_b;
    logic [15:0] acc_x, acc_y, acc_z, gyro_x, gyro_y, gyro_z;
    logic        tx_a, busy_a, fd_a, ovr_a;
    logic        tx_b, busy_b, fd_b, ovr_b;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int st [15];
    int t0, p, b0, b1;
    logic mon_clr;
    int busy_cnt, fd_cnt, fd_cyc, low_cnt;
    logic [7:0] exp_f [15];

    logic [7:0] f_base [15] = '{8'h55, 8'hAA, 8'h12, 8'h34, 8'h00, 8'h00, 8'h00, 8'h00,
                                8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h46};
    logic [7:0] f_beef [15] = '{8'h55, 8'hAA, 8'hBE, 8'hEF, 8'hBE, 8'hEF, 8'hBE, 8'hEF,
                                8'hBE, 8'hEF, 8'hBE, 8'hEF, 8'hBE, 8'hEF, 8'h0E};
    logic [7:0] f_mix  [15] = '{8'h55, 8'hAA, 8'hFF, 8'hFF, 8'h00, 8'h00, 8'h00, 8'h00,
                                8'h00, 8'h00, 8'h00, 8'h00, 8'h01, 8'h02, 8'h01};

    imu_uart_telemetry #(.CLK_HZ(1000000), .BAUD(100000), .FRAME_PERIOD(2000)) dut_a (
        .clk(clk), .rst_n(rst_n_a), .enable(en_a),
        .acc_x(acc_x), .acc_y(acc_y), .acc_z(acc_z),
        .gyro_x(gyro_x), .gyro_y(gyro_y), .gyro_z(gyro_z),
        .tx(tx_a), .busy(busy_a), .frame_done(fd_a), .overrun(ovr_a));

    imu_uart_telemetry #(.CLK_HZ(1000000), .BAUD(100000), .FRAME_PERIOD(1000)) dut_b (
        .clk(clk), .rst_n(rst_n_b), .enable(en_b),
        .acc_x(acc_x), .acc_y(acc_y), .acc_z(acc_z),
        .gyro_x(gyro_x), .gyro_y(gyro_y), .gyro_z(gyro_z),
        .tx(tx_b), .busy(busy_b), .frame_done(fd_b), .overrun(ovr_b));

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (mon_clr) begin
            busy_cnt <= 0;
            fd_cnt   <= 0;
            fd_cyc   <= 0;
            low_cnt  <= 0;
        end else begin
            if (busy_a) busy_cnt <= busy_cnt + 1;
            if (fd_a) begin
                fd_cnt <= fd_cnt + 1;
                fd_cyc <= cyc;
            end
            if (tx_a !== 1'b1) low_cnt <= low_cnt + 1;
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic cur_tx(input int sel);
        return (sel != 0) ? tx_b : tx_a;
    endfunction

    task automatic clr_mon();
        mon_clr = 1'b1;
        @(negedge clk);
        #1 mon_clr = 1'b0;
    endtask

    // Decode bytes first..last of a frame, sampling each bit mid-cell.
    task automatic recv_bytes(input int sel, input int first, input int last);
        for (int i = first; i <= last; i++) begin
            logic [7:0] b;
            int n;
            n = 0;
            @(negedge clk);
            while (cur_tx(sel) !== 1'b0 && n < 4000) begin
                @(negedge clk);
                n++;
            end
            chk($sformatf("start_wait_b%0d", i), (n < 4000) ? 32'd1 : 32'd0, 32'd1);
            st[i] = cyc;
            repeat (15) @(negedge clk);
            b[0] = cur_tx(sel);
            for (int k = 1; k < 8; k++) begin
                repeat (10) @(negedge clk);
                b[k] = cur_tx(sel);
            end
            repeat (10) @(negedge clk);
            chk($sformatf("stop_bit_b%0d", i), {31'd0, cur_tx(sel)}, 32'd1);
            chk($sformatf("byte%0d", i), {24'd0, b}, {24'd0, exp_f[i]});
        end
    endtask

    initial begin
        rst_n_a = 1'b0; rst_n_b = 1'b0; en_a = 1'b0; en_b = 1'b0; mon_clr = 1'b1;
        acc_x = '0; acc_y = '0; acc_z = '0; gyro_x = '0; gyro_y = '0; gyro_z = '0;
        repeat (3) @(negedge clk);
        chk("rst_tx", {31'd0, tx_a}, 32'd1);
        chk("rst_busy", {31'd0, busy_a}, 32'd0);
        chk("rst_frame_done", {31'd0, fd_a}, 32'd0);
        chk("rst_overrun", {31'd0, ovr_a}, 32'd0);

        // First frame: tick at cycle 1999, start bit on edge 2001.
        acc_x = 16'h1234; en_a = 1'b1; rst_n_a = 1'b1; t0 = cyc;
        clr_mon();
        exp_f = f_base;
        recv_bytes(0, 0, LEN - 1);
        chk("first_start_cycle", st[0] - t0, 2001);
        chk("byte_spacing", st[1] - st[0], 10 * BDIV + 2);
        repeat (10) @(negedge clk);
        chk("frame_done_count", fd_cnt, 1);
        chk("busy_cycles", busy_cnt, FRAME_CYC);
        chk("frame_done_offset", fd_cyc - st[0], FRAME_CYC - 1);
        chk("overrun_a", {31'd0, ovr_a}, 32'd0);

        // Inputs change mid-frame; snapshot must hold.
        recv_bytes(0, 0, 3);
        chk("second_start_cycle", st[0] - t0, 4001);
        acc_x = 16'hBEEF; acc_y = 16'hBEEF; acc_z = 16'hBEEF;
        gyro_x = 16'hBEEF; gyro_y = 16'hBEEF; gyro_z = 16'hBEEF;
        recv_bytes(0, 4, LEN - 1);
        exp_f = f_beef;
        recv_bytes(0, 0, LEN - 1);

        // Mixed pattern frame; enable dropped mid-frame.
        acc_x = 16'hFFFF; acc_y = '0; acc_z = '0; gyro_x = '0; gyro_y = '0; gyro_z = 16'h0102;
        exp_f = f_mix;
        recv_bytes(0, 0, 2);
        en_a = 1'b0;
        recv_bytes(0, 3, LEN - 1);
        repeat (10) @(negedge clk);
        clr_mon();
        repeat (3000) @(negedge clk);
        chk("disabled_tx_low_samples", low_cnt, 0);
        chk("disabled_busy", busy_cnt, 0);
        chk("disabled_frame_done", fd_cnt, 0);
        en_a = 1'b1; p = cyc;
        recv_bytes(0, 0, LEN - 1);
        chk("reenable_start_cycle", st[0] - p, 2001);

        // DUT B: second tick lands while busy.
        acc_x = 16'h1234; acc_y = '0; acc_z = '0; gyro_x = '0; gyro_y = '0; gyro_z = '0;
        exp_f = f_base;
        rst_n_b = 1'b1; en_b = 1'b1; b0 = cyc;
        recv_bytes(1, 0, LEN - 1);
        chk("b_first_start", st[0] - b0, 1001);
        chk("b_overrun_set", {31'd0, ovr_b}, 32'd1);
        recv_bytes(1, 0, LEN - 1);
        chk("b_second_start", st[0] - b0, 3001);
        chk("b_overrun_sticky", {31'd0, ovr_b}, 32'd1);

        // Reset during byte 5 of the third frame.
        recv_bytes(1, 0, 4);
        chk("b_third_start", st[0] - b0, 5001);
        repeat (20) @(negedge clk);
        chk("b_pre_reset_tx", {31'd0, tx_b}, 32'd0);
        chk("b_pre_reset_busy", {31'd0, busy_b}, 32'd1);
        rst_n_b = 1'b0;
        #1;
        chk("b_reset_tx", {31'd0, tx_b}, 32'd1);
        chk("b_reset_busy", {31'd0, busy_b}, 32'd0);
        chk("b_reset_overrun", {31'd0, ovr_b}, 32'd0);
        chk("b_reset_frame_done", {31'd0, fd_b}, 32'd0);
        @(negedge clk);
        rst_n_b = 1'b1; b1 = cyc;
        recv_bytes(1, 0, 0);
        chk("b_post_reset_start", st[0] - b1, 1001);
        chk("b_post_reset_overrun", {31'd0, ovr_b}, 32'd0);
        recv_bytes(1, 1, LEN - 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/imu_uart_telemetry.md
Name: imu_uart_telemetry

Overview:
- Downstream consumer of the MPU6050 I2C reader's six 16-bit axis outputs (ACC_X/Y/Z, GYRO_X/Y/Z).
- Periodically snapshots all six words into a coherent register set and serialises them as a framed 8N1 UART stream to a host or logger.
- The reader exposes no valid strobe and updates bytes independently, so the snapshot is taken on a local frame tick, never on data change.

Parameters:
- CLK_HZ, 50000000, system clock frequency in Hz.
- BAUD, 115200, UART bit rate. BAUD_DIV = CLK_HZ/BAUD, truncated, minimum 2.
- FRAME_PERIOD, 500000, clk cycles between frame ticks (10 ms at 50 MHz, matching the reader poll rate).

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous, active-low reset.
- enable  in  1  frame-tick generation enable.
- acc_x  in  16  accelerometer X, high byte in [15:8].
- acc_y  in  16  accelerometer Y.
- acc_z  in  16  accelerometer Z.
- gyro_x  in  16  gyroscope X.
- gyro_y  in  16  gyroscope Y.
- gyro_z  in  16  gyroscope Z.
- tx  out  1  UART serial output; idles high.
- busy  out  1  high from snapshot through end of the last stop bit.
- frame_done  out  1  one-cycle pulse after the last stop bit of each frame.
- overrun  out  1  sticky; set when a tick arrives while busy. Cleared only by reset.

Behaviour:
- Reset values: tx=1, busy=0, frame_done=0, overrun=0, period counter=0, snapshot registers=0, FSM=IDLE.
- Period counter:
  - Counts 0..FRAME_PERIOD-1 while enable=1; tick is asserted on FRAME_PERIOD-1, then the counter wraps to 0.
  - enable=0 holds the counter at 0 and generates no ticks. A frame already in progress always completes.
- FSM states: IDLE, LOAD, SEND, NEXT, DONE.
  - IDLE: on tick, capture all six inputs into the snapshot in that same cycle, set busy=1, byte index=0, go to LOAD.
  - LOAD: place frame byte[index] into the shift register, start the bit timer, go to SEND.
  - SEND: drive 10 bits (start=0, 8 data bits LSB first, stop=1), each held exactly BAUD_DIV cycles.
  - NEXT: if index is the last byte, go to DONE; otherwise increment index and go to LOAD. Inter-byte gap is exactly 2 idle-high cycles (NEXT, LOAD).
  - DONE: pulse frame_done=1 for one cycle, busy=0, return to IDLE.
- Latency: tx falls to the start bit on the second clk edge after the tick cycle.
- Frame byte order: 0x55, 0xAA, then acc_x hi, acc_x lo, acc_y hi, acc_y lo, acc_z hi, acc_z lo, gyro_x hi, gyro_x lo, gyro_y hi, gyro_y lo, gyro_z hi, gyro_z lo.
  - Base frame is 14 bytes.
  - Frame duration is 14*10*BAUD_DIV + 2*13 + 2 cycles from the first tx fall to the frame_done pulse. The +2 covers the final NEXT and DONE cycles.
- Data is taken only from the snapshot. Input changes during a frame do not affect the bytes sent.
- A tick while busy is dropped and sets overrun=1. A tick on the same cycle as DONE is also dropped. Ticks are not queued.
- Reset mid-frame: tx returns high immediately and the partial frame is abandoned.

Optional Feature:
- Macro: IMU_TLM_CHECKSUM_EN.
- Defined:
  - A 15th byte is appended: 8-bit modulo-256 sum of the 12 data bytes (headers excluded).
  - The sum is accumulated as bytes load; no extra latency is added.
  - Frame length becomes 15 bytes.
- Undefined: 14-byte frame, no adder logic.

Decomposition:
- Shared package imu_tlm_pkg:
  - FSM state encoding constants.
  - Header constants 0x55/0xAA.
  - Frame length constants: 14 base, 15 with checksum.
  - Byte-index width.
- Sub-module uart_tx_byte:
  - Ports: clk, rst_n, start, data[7:0], tx, done.
  - Contains the BAUD_DIV bit timer and 10-bit shifter.
  - The top-level FSM sequences bytes through it.

Test Plan:
All tests use CLK_HZ=1000000, BAUD=100000 (BAUD_DIV=10), FRAME_PERIOD=2000.
1. Reset release, enable=1, acc_x=0x1234, all others 0 → first tick at cycle 1999. tx falls at tick+2. Decoded bytes: 55 AA 12 34 00×10. frame_done pulses once; busy is high for the frame duration.
2. Same stimulus with IMU_TLM_CHECKSUM_EN defined → 15 bytes, last byte 0x46. Then acc_x=0xFFFF, gyro_z=0x0102 → checksum 0x01.
3. Change every input to 0xBEEF mid-frame (after byte 3) → the remainder of the frame still carries the original snapshot values. The next frame carries BE EF.
4. FRAME_PERIOD=1000 (shorter than the 1428-cycle frame) → the second tick lands while busy, overrun=1 and stays set. The next frame starts on the third tick, and no frame is ever truncated.
5. Drop enable to 0 mid-frame → the current frame completes, no further ticks, tx stays high. Re-enable → first tick exactly FRAME_PERIOD cycles later.
6. Assert rst_n low during byte 5 → within the same cycle tx=1, busy=0, overrun=0. After release, normal framing resumes from the first tick.
